// File: rtl/rat_control_unit.sv
// RAT fetch/execute control FSM: two-cycle FETCH/EXEC rhythm driving PC, register file, ALU, flags, stack and I/O strobes.
// Optional interrupt support (SEI/CLI/RETIE, ST_INTR vectoring to 0x3FF) is enabled by defining RAT_INTR_EN.
module rat_control_unit #(
   parameter int INIT_CYCLES = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] IR_OP,
   input  logic       C_FLAG,
   input  logic       Z_FLAG,
   input  logic       INTR,
   output logic       RST_OUT,
   output logic       PC_LD,
   output logic       PC_INC,
   output logic [1:0] PC_MUX_SEL,
   output logic       RF_WR,
   output logic [3:0] ALU_SEL,
   output logic       ALU_OPY_SEL,
   output logic       FLG_C_LD,
   output logic       FLG_Z_LD,
   output logic       SP_INCR,
   output logic       SP_DECR,
   output logic       SCR_WE,
   output logic       IO_STRB
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_INTR  = 3'd3
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_MOV  = 5'b00100;
   localparam logic [4:0] OP_OUT  = 5'b00101;
   localparam logic [4:0] OP_BRN  = 5'b01000;
   localparam logic [4:0] OP_BREQ = 5'b01001;
   localparam logic [4:0] OP_BRNE = 5'b01010;
   localparam logic [4:0] OP_BRCS = 5'b01011;
   localparam logic [4:0] OP_CALL = 5'b01100;
   localparam logic [4:0] OP_RET  = 5'b01101;
`ifdef RAT_INTR_EN
   localparam logic [4:0] OP_SEI  = 5'b01110;
   localparam logic [4:0] OP_CLI  = 5'b01111;
`endif

   localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

   state_t     state;
   logic [3:0] init_cnt;
   logic [4:0] opcode;

   assign opcode = IR_OP[5:1];

`ifdef RAT_INTR_EN
   logic ie;
`else
   logic unused_intr;
   assign unused_intr = INTR;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= ST_INIT;
         init_cnt <= '0;
`ifdef RAT_INTR_EN
         ie       <= 1'b0;
`endif
      end else begin
         case (state)
            ST_INIT: begin
               if (init_cnt == INIT_LAST) begin
                  init_cnt <= '0;
                  state    <= ST_FETCH;
               end else begin
                  init_cnt <= init_cnt + 4'd1;
               end
            end
            ST_FETCH: state <= ST_EXEC;
            ST_EXEC: begin
`ifdef RAT_INTR_EN
               // The interrupt decision uses IE as it stood during this EXEC.
               if (opcode == OP_SEI || (opcode == OP_RET && IR_OP[0]))
                  ie <= 1'b1;
               else if (opcode == OP_CLI)
                  ie <= 1'b0;
               state <= (INTR && ie) ? ST_INTR : ST_FETCH;
`else
               state <= ST_FETCH;
`endif
            end
`ifdef RAT_INTR_EN
            ST_INTR: begin
               ie    <= 1'b0;
               state <= ST_FETCH;
            end
`endif
            default: begin
               init_cnt <= '0;
               state    <= ST_INIT;
            end
         endcase
      end
   end

   // Strobes decode from the registered state so an async reset kills them at once.
   always_comb begin
      RST_OUT     = 1'b0;
      PC_LD       = 1'b0;
      PC_INC      = 1'b0;
      PC_MUX_SEL  = 2'd0;
      RF_WR       = 1'b0;
      ALU_SEL     = 4'b0000;
      ALU_OPY_SEL = 1'b0;
      FLG_C_LD    = 1'b0;
      FLG_Z_LD    = 1'b0;
      SP_INCR     = 1'b0;
      SP_DECR     = 1'b0;
      SCR_WE      = 1'b0;
      IO_STRB     = 1'b0;
      case (state)
         ST_INIT:  RST_OUT = 1'b1;
         ST_FETCH: PC_INC  = 1'b1;
         ST_EXEC: begin
            case (opcode)
               OP_ADD: begin
                  RF_WR = 1'b1; ALU_SEL = 4'b0000; FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
                  ALU_OPY_SEL = IR_OP[0];
               end
               OP_SUB: begin
                  RF_WR = 1'b1; ALU_SEL = 4'b0010; FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
                  ALU_OPY_SEL = IR_OP[0];
               end
               OP_AND: begin
                  RF_WR = 1'b1; ALU_SEL = 4'b0101; FLG_Z_LD = 1'b1;
                  ALU_OPY_SEL = IR_OP[0];
               end
               OP_OR: begin
                  RF_WR = 1'b1; ALU_SEL = 4'b0110; FLG_Z_LD = 1'b1;
                  ALU_OPY_SEL = IR_OP[0];
               end
               OP_MOV: begin
                  RF_WR = 1'b1; ALU_SEL = 4'b1110;
                  ALU_OPY_SEL = IR_OP[0];
               end
               OP_OUT:  IO_STRB = 1'b1;
               OP_BRN:  PC_LD = 1'b1;
               OP_BREQ: PC_LD = Z_FLAG;
               OP_BRNE: PC_LD = !Z_FLAG;
               OP_BRCS: PC_LD = C_FLAG;
               OP_CALL: begin
                  PC_LD = 1'b1; SCR_WE = 1'b1; SP_DECR = 1'b1;
               end
               OP_RET: begin
                  PC_LD = 1'b1; PC_MUX_SEL = 2'd1; SP_INCR = 1'b1;
               end
               default: ;
            endcase
         end
`ifdef RAT_INTR_EN
         ST_INTR: begin
            PC_LD      = 1'b1;
            PC_MUX_SEL = 2'd2;
            SCR_WE     = 1'b1;
            SP_DECR    = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rat_control_unit.sv
// Bench for rat_control_unit: directed plan steps then random opcodes, checked each cycle against a reference model.
module tb_rat_control_unit;
   localparam int INIT_CYCLES = 3;

`ifdef RAT_INTR_EN
   localparam bit INTR_FEATURE = 1'b1;
`else
   localparam bit INTR_FEATURE = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic [5:0] IR_OP;
   logic       C_FLAG, Z_FLAG, INTR;
   logic       RST_OUT, PC_LD, PC_INC, RF_WR, ALU_OPY_SEL, FLG_C_LD, FLG_Z_LD;
   logic       SP_INCR, SP_DECR, SCR_WE, IO_STRB;
   logic [1:0] PC_MUX_SEL;
   logic [3:0] ALU_SEL;

   always #5 CLK = ~CLK;

   rat_control_unit #(.INIT_CYCLES(INIT_CYCLES)) dut (
      .CLK(CLK), .RST(RST), .IR_OP(IR_OP), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .INTR(INTR),
      .RST_OUT(RST_OUT), .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_MUX_SEL(PC_MUX_SEL),
      .RF_WR(RF_WR), .ALU_SEL(ALU_SEL), .ALU_OPY_SEL(ALU_OPY_SEL),
      .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .SP_INCR(SP_INCR), .SP_DECR(SP_DECR),
      .SCR_WE(SCR_WE), .IO_STRB(IO_STRB)
   );

   logic [16:0] dut_out;
   assign dut_out = {RST_OUT, PC_LD, PC_INC, PC_MUX_SEL, RF_WR, ALU_SEL, ALU_OPY_SEL,
                     FLG_C_LD, FLG_Z_LD, SP_INCR, SP_DECR, SCR_WE, IO_STRB};

   int n_vec = 0;
   int n_err = 0;

   // Reference model: cycles of init left, whether the next cycle executes, pending vector, IE.
   int m_init_left;
   bit m_exec, m_intr, m_ie;

   function automatic logic [16:0] pk(input logic ro, ld, inc, input logic [1:0] mux,
                                      input logic wr, input logic [3:0] alu,
                                      input logic opy, cld, zld, spi, spd, scr, io);
      return {ro, ld, inc, mux, wr, alu, opy, cld, zld, spi, spd, scr, io};
   endfunction

   function automatic logic [16:0] decode(input logic [5:0] op, input logic c, input logic z);
      logic im;
      im = op[0];
      case (op[5:1])
         5'd0:  return pk(0, 0, 0, 2'd0, 1, 4'b0000, im, 1, 1, 0, 0, 0, 0);
         5'd1:  return pk(0, 0, 0, 2'd0, 1, 4'b0010, im, 1, 1, 0, 0, 0, 0);
         5'd2:  return pk(0, 0, 0, 2'd0, 1, 4'b0101, im, 0, 1, 0, 0, 0, 0);
         5'd3:  return pk(0, 0, 0, 2'd0, 1, 4'b0110, im, 0, 1, 0, 0, 0, 0);
         5'd4:  return pk(0, 0, 0, 2'd0, 1, 4'b1110, im, 0, 0, 0, 0, 0, 0);
         5'd5:  return pk(0, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1);
         5'd8:  return pk(0, 1, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
         5'd9:  return pk(0, z, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
         5'd10: return pk(0, !z, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
         5'd11: return pk(0, c, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
         5'd12: return pk(0, 1, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 1, 1, 0);
         5'd13: return pk(0, 1, 0, 2'd1, 0, 4'b0000, 0, 0, 0, 1, 0, 0, 0);
         default: return 17'd0;
      endcase
   endfunction

   function automatic logic [16:0] model_expect(input logic [5:0] op, input logic c, input logic z);
      if (m_init_left > 0) return pk(1, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
      if (m_intr)          return pk(0, 1, 0, 2'd2, 0, 4'b0000, 0, 0, 0, 0, 1, 1, 0);
      if (m_exec)          return decode(op, c, z);
      return pk(0, 0, 1, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic model_reset();
      m_init_left = INIT_CYCLES;
      m_exec = 1'b0;
      m_intr = 1'b0;
      m_ie   = 1'b0;
   endtask

   task automatic model_step(input logic [5:0] op, input logic intr);
      if (m_init_left > 0) begin
         m_init_left--;
      end else if (m_intr) begin
         m_intr = 1'b0;
         m_ie   = 1'b0;
      end else if (m_exec) begin
         m_exec = 1'b0;
         m_intr = INTR_FEATURE && intr && m_ie;
         if (INTR_FEATURE) begin
            if (op[5:1] == 5'd14 || (op[5:1] == 5'd13 && op[0])) m_ie = 1'b1;
            else if (op[5:1] == 5'd15)                            m_ie = 1'b0;
         end
      end else begin
         m_exec = 1'b1;
      end
   endtask

   task automatic check(input string tag, input logic [16:0] exp);
      n_vec++;
      assert (dut_out === exp) else begin
         n_err++;
         $error("FAIL %s: observed %05h expected %05h", tag, dut_out, exp);
      end
      n_vec++;
      assert (((PC_LD & PC_INC) | (SP_INCR & SP_DECR)) === 1'b0) else begin
         n_err++;
         $error("FAIL %s_overlap: observed ld/inc=%b%b spi/spd=%b%b expected no pair high",
                tag, PC_LD, PC_INC, SP_INCR, SP_DECR);
      end
   endtask

   task automatic cycle(input logic rst, input logic [5:0] op, input logic c, input logic z,
                        input logic intr, input string tag);
      RST = rst; IR_OP = op; C_FLAG = c; Z_FLAG = z; INTR = intr;
      if (!rst) model_reset();
      @(negedge CLK);
      check(tag, model_expect(op, c, z));
      @(posedge CLK);
      if (rst) model_step(op, intr);
      #1;
   endtask

   initial begin
      logic [5:0] op;
      logic       c, z, ir;
      RST = 1'b1; IR_OP = '0; C_FLAG = 1'b0; Z_FLAG = 1'b0; INTR = 1'b0;
      #2 RST = 1'b0;
      model_reset();
      @(posedge CLK); #1;
      cycle(0, 6'b000000, 0, 0, 0, "reset_hold");
      cycle(0, 6'b011000, 1, 1, 1, "reset_hold2");
      for (int i = 0; i < INIT_CYCLES; i++) cycle(1, 6'b000000, 0, 0, 0, "init");
      cycle(1, 6'b000001, 0, 0, 0, "first_fetch");
      cycle(1, 6'b000001, 0, 0, 0, "add_imm");
      cycle(1, 6'b010010, 0, 0, 0, "fetch");
      cycle(1, 6'b010010, 0, 0, 0, "breq_z0");
      cycle(1, 6'b010010, 0, 1, 0, "fetch");
      cycle(1, 6'b010010, 0, 1, 0, "breq_z1");
      cycle(1, 6'b011000, 0, 0, 0, "fetch");
      cycle(1, 6'b011000, 0, 0, 0, "call");
      cycle(1, 6'b011010, 0, 0, 0, "fetch");
      cycle(1, 6'b011010, 0, 0, 0, "ret");
      cycle(1, 6'b000110, 0, 0, 0, "fetch");
      cycle(1, 6'b000110, 0, 0, 0, "or_reg");
      cycle(1, 6'b001010, 0, 0, 0, "fetch");
      cycle(1, 6'b001010, 0, 0, 0, "out");
      cycle(1, 6'b010110, 1, 0, 0, "fetch");
      cycle(1, 6'b010110, 1, 0, 0, "brcs_c1");
      cycle(1, 6'b011100, 0, 0, 1, "fetch");
      cycle(1, 6'b011100, 0, 0, 0, "sei");
      cycle(1, 6'b000000, 0, 0, 0, "fetch");
      cycle(1, 6'b000000, 0, 0, 1, "add_with_intr");
      cycle(1, 6'b000000, 0, 0, 1, "intr_vector");
      cycle(1, 6'b000000, 0, 0, 1, "fetch");
      cycle(1, 6'b000000, 0, 0, 1, "add_no_reentry");
      cycle(1, 6'b000000, 0, 0, 1, "fetch_no_vector");
      cycle(1, 6'b011011, 0, 0, 0, "retie");
      cycle(1, 6'b011011, 0, 0, 0, "fetch");
      cycle(1, 6'b111110, 0, 0, 1, "nop_with_intr");
      cycle(1, 6'b111110, 0, 0, 0, "intr_after_retie");
      cycle(1, 6'b011000, 0, 0, 0, "fetch");
      cycle(1, 6'b011000, 0, 0, 0, "exec_after");
      cycle(1, 6'b011000, 0, 0, 0, "fetch_call");

      // Abort a CALL mid-EXEC: strobes must drop as soon as RST falls.
      IR_OP = 6'b011000;
      @(negedge CLK);
      check("call_before_abort", model_expect(6'b011000, 0, 0));
      #1 RST = 1'b0;
      model_reset();
      #1 check("call_abort", model_expect(6'b011000, 0, 0));
      @(posedge CLK); #1;
      cycle(0, 6'b011000, 0, 0, 0, "abort_hold");
      for (int i = 0; i < INIT_CYCLES; i++) cycle(1, 6'b011000, 0, 0, 0, "reinit");

      for (int i = 0; i < 400; i++) begin
         op = 6'($urandom_range(0, 63));
         c  = 1'($urandom_range(0, 1));
         z  = 1'($urandom_range(0, 1));
         ir = ($urandom_range(0, 3) == 0);
         cycle(1, op, c, z, ir, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rat_control_unit.md
Name: rat_control_unit

Overview:
- Fetch/execute control FSM sitting directly downstream of the program counter and program ROM stage.
- Consumes the opcode field of PROG_IR and drives PC_LD, PC_INC and PC_MUX_SEL back into that stage.
- Also drives the control strobes for the register file, ALU, flags, scratch/stack and I/O.
- Two-cycle instruction rhythm: FETCH (PC advances, ROM reads synchronously), then EXEC (decode, assert strobes).

Parameters:
INIT_CYCLES, 1, number of cycles RST_OUT is held high after reset release (1..15).

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
IR_OP  input  6  PROG_IR[17:12]; [5:1] = opcode, [0] = immediate select
C_FLAG  input  1  carry flag
Z_FLAG  input  1  zero flag
INTR  input  1  level interrupt request
RST_OUT  output  1  synchronous reset to PC, stack pointer and flags
PC_LD  output  1  load PC from the mux
PC_INC  output  1  increment PC
PC_MUX_SEL  output  2  0 = FROM_IMMED, 1 = FROM_STACK, 2 = vector 0x3FF
RF_WR  output  1  register file write
ALU_SEL  output  4  ALU operation
ALU_OPY_SEL  output  1  ALU Y operand: 0 = register, 1 = immediate
FLG_C_LD  output  1  load C flag
FLG_Z_LD  output  1  load Z flag
SP_INCR  output  1  stack pointer +1 (pop)
SP_DECR  output  1  stack pointer -1 (push)
SCR_WE  output  1  scratch RAM write (push PC)
IO_STRB  output  1  output-port strobe

Behaviour:
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_INTR. Any illegal encoding goes to ST_INIT.
- Reset (RST=0, asynchronous):
  - State = ST_INIT; init counter = 0; interrupt enable IE = 0.
  - All outputs 0 except RST_OUT = 1.
  - Reset asserted mid-operation aborts immediately; no strobe completes.
- ST_INIT:
  - RST_OUT = 1; counter increments each cycle.
  - When counter == INIT_CYCLES-1, go to ST_FETCH.
- ST_FETCH:
  - PC_INC = 1 for exactly one cycle; all other strobes 0.
  - Next state is ST_EXEC.
- ST_EXEC:
  - Outputs are combinational from IR_OP and the flags; next state is ST_FETCH.
  - Decode by IR_OP[5:1]; unlisted strobes are 0:
    - 00000 ADD: RF_WR, ALU_SEL=0000, FLG_C_LD, FLG_Z_LD
    - 00001 SUB: RF_WR, ALU_SEL=0010, FLG_C_LD, FLG_Z_LD
    - 00010 AND: RF_WR, ALU_SEL=0101, FLG_Z_LD
    - 00011 OR: RF_WR, ALU_SEL=0110, FLG_Z_LD
    - 00100 MOV: RF_WR, ALU_SEL=1110, no flag loads
    - 00101 OUT: IO_STRB
    - 01000 BRN: PC_LD, PC_MUX_SEL=0
    - 01001 BREQ: PC_LD = Z_FLAG
    - 01010 BRNE: PC_LD = !Z_FLAG
    - 01011 BRCS: PC_LD = C_FLAG
    - 01100 CALL: PC_LD, PC_MUX_SEL=0, SCR_WE, SP_DECR
    - 01101 RET: PC_LD, PC_MUX_SEL=1, SP_INCR
    - All other opcodes: NOP.
  - ALU_OPY_SEL = IR_OP[0] for opcodes 00000-00100; 0 otherwise.
  - CALL pushes the already-incremented PC, i.e. the return address.
- Invariant: PC_LD and PC_INC are never high in the same cycle.
- Invariant: SP_INCR and SP_DECR are never high in the same cycle.
- Latency: each instruction takes 2 cycles; the first FETCH occurs INIT_CYCLES cycles after RST rises.

Optional Feature:
RAT_INTR_EN
- Defined:
  - 01110 SEI sets IE; 01111 CLI clears IE.
  - RET with IR_OP[0]=1 (RETIE) performs RET and sets IE.
  - At the end of ST_EXEC, if INTR && IE, go to ST_INTR instead of ST_FETCH.
  - ST_INTR lasts one cycle: PC_LD=1, PC_MUX_SEL=2, SCR_WE=1, SP_DECR=1, IE cleared; then ST_FETCH.
  - The EXEC strobes of the current instruction still issue in full.
  - INTR is level-sensitive and not latched; a request seen while IE=0 is lost.
- Undefined:
  - INTR is ignored; SEI and CLI are NOPs; RETIE behaves as RET.
  - ST_INTR is unreachable and PC_MUX_SEL never equals 2.

Test Plan:
- Reset with INIT_CYCLES=3: hold RST=0 then release -> RST_OUT=1 for 3 cycles, then PC_INC=1 on the 4th cycle, then alternating FETCH/EXEC.
- IR_OP=000001 (ADD immediate) in EXEC -> RF_WR=1, ALU_SEL=0000, ALU_OPY_SEL=1, FLG_C_LD=1, FLG_Z_LD=1 for one cycle; PC_LD=0.
- BREQ (IR_OP=010010) with Z_FLAG=0, then again with Z_FLAG=1 -> PC_LD=0, then PC_LD=1 with PC_MUX_SEL=0.
- CALL then RET -> CALL cycle: SCR_WE=1, SP_DECR=1, PC_LD=1, MUX=0; RET cycle: SP_INCR=1, PC_LD=1, MUX=1.
- Drive RST=0 mid-EXEC of CALL -> SCR_WE and PC_LD drop within the same cycle; state returns to INIT with RST_OUT=1.
- With RAT_INTR_EN: SEI, then INTR=1 during an ADD -> ADD strobes issue, next cycle PC_LD=1, MUX=2, SCR_WE=1, SP_DECR=1; a second INTR is ignored until RETIE.
